// File: rtl/proc_host_ctrl.sv
// Host-side initiator for the processor init/req/ack run handshake.
// Pulses init, issues req, then times the wait for ack with a timeout.
module proc_host_ctrl #(
  parameter int INIT_CYC = 4,
  parameter int REQ_CYC  = 1,
  parameter int CW       = 16,
  parameter int TIMEOUT  = 10000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          abort,
  input  logic          ack,
  output logic          init,
  output logic          req,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic [7:0]    run_count,
  output logic [2:0]    state_dbg
);

  // Handshake: init and req are level outputs decoded from the state register;
  // ack is only honoured in S_WAIT, start only in S_IDLE/S_DONE/S_TOUT.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_TOUT = 3'd5
  } state_t;

  localparam int MAXC  = (INIT_CYC > REQ_CYC) ? INIT_CYC : REQ_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_CYC - 1);
  localparam logic [CW-1:0]    TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    TO_VAL    = CW'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic [7:0]       run_count_q, run_count_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cycles_q    <= '0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      run_count_q <= run_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
    run_count_d = run_count_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_TOUT: begin
          if (start) begin
            state_d = S_INIT;
            cnt_d   = '0;
          end
        end
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            state_d  = S_REQ;
            cnt_d    = '0;
            cycles_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REQ: begin
          if (cnt_q == REQ_LAST) state_d = S_WAIT;
          else cnt_d = cnt_q + CNT_W'(1);
        end
        S_WAIT: begin
          // ack wins over the timeout check in the same cycle
          if (ack) begin
            state_d     = S_DONE;
            run_count_d = run_count_q + 8'd1;
          end else if (cycles_q == TO_LAST) begin
            state_d  = S_TOUT;
            cycles_d = TO_VAL;
          end else begin
            cycles_d = cycles_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign init      = (state_q == S_INIT);
  assign req       = (state_q == S_REQ);
  assign busy      = (state_q == S_INIT) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign done      = (state_q == S_DONE);
  assign timeout   = (state_q == S_TOUT);
  assign cycles    = cycles_q;
  assign run_count = run_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_proc_host_ctrl.sv
// Bench for proc_host_ctrl: per-run transaction model of the init/req/ack
// sequence with randomized ack delay and stray start pulses.
module tb_proc_host_ctrl;

  localparam int INIT_CYC = 4;
  localparam int REQ_CYC  = 1;
  localparam int CW       = 16;
  localparam int TIMEOUT  = 20;

  logic          Clk = 1'b0;
  logic          Reset, start, abort, ack;
  logic          init, req, busy, done, timeout;
  logic [CW-1:0] cycles;
  logic [7:0]    run_count;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  // Reference: result of a run is fully determined by when ack arrives.
  int            mdl_runs;
  logic [CW-1:0] mdl_cycles;
  logic [CW-1:0] exp_q[$];

  proc_host_ctrl #(
    .INIT_CYC(INIT_CYC), .REQ_CYC(REQ_CYC), .CW(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .ack(ack),
    .init(init), .req(req), .busy(busy), .done(done), .timeout(timeout),
    .cycles(cycles), .run_count(run_count), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    Reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    mdl_runs = 0; mdl_cycles = '0;
  endtask

  // One full run launched from IDLE/DONE/TOUT. ack_at is the WAIT cycle index
  // (0 = first WAIT cycle) at which ack rises; outside 0..TIMEOUT-1 means never.
  task automatic do_run(input int ack_at, input bit ack_early, input bit noise, input bit wave);
    int  end_w;
    bit  hit;
    logic [4:0] exp_flags;
    logic [CW-1:0] exp_c;
    hit   = (ack_at >= 0) && (ack_at < TIMEOUT);
    end_w = hit ? ack_at : TIMEOUT - 1;
    start = 1'b1; ack = ack_early;
    tick();
    start = 1'b0;
    for (int i = 0; i < INIT_CYC; i++) begin
      if (wave) begin
        total++;
        if ({init, req, busy, done, timeout} !== 5'b10100 || cycles !== mdl_cycles) begin
          bad++;
          $display("FAIL init_phase i=%0d flags(init,req,busy,done,tout)=%b cycles=%0d want 10100 cycles=%0d",
                   i, {init, req, busy, done, timeout}, cycles, mdl_cycles);
        end
      end
      start = noise && (i == 0);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < REQ_CYC; i++) begin
      if (wave) begin
        total++;
        if ({init, req, busy, done, timeout} !== 5'b01100 || cycles !== '0) begin
          bad++;
          $display("FAIL req_phase i=%0d flags=%b cycles=%0d want 01100 cycles=0",
                   i, {init, req, busy, done, timeout}, cycles);
        end
      end
      tick();
    end
    for (int w = 0; w <= end_w; w++) begin
      if (wave) begin
        total++;
        if ({init, req, busy, done, timeout} !== 5'b00100 || cycles !== CW'(w)) begin
          bad++;
          $display("FAIL wait_phase w=%0d flags=%b cycles=%0d want 00100 cycles=%0d",
                   w, {init, req, busy, done, timeout}, cycles, w);
        end
      end
      ack   = ack_early || (hit && (w == ack_at));
      start = noise && (w == 1);
      tick();
    end
    ack = 1'b0; start = 1'b0;
    if (hit) begin
      mdl_runs   = (mdl_runs + 1) % 256;
      mdl_cycles = CW'(ack_at);
    end else begin
      mdl_cycles = CW'(TIMEOUT);
    end
    exp_q.push_back(mdl_cycles);
    exp_flags = hit ? 5'b00010 : 5'b00001;
    exp_c = exp_q.pop_front();
    total++;
    if ({init, req, busy, done, timeout} !== exp_flags || cycles !== exp_c ||
        run_count !== mdl_runs[7:0]) begin
      bad++;
      $display("FAIL run_end ack_at=%0d flags=%b cycles=%0d run_count=%0d want %b %0d %0d",
               ack_at, {init, req, busy, done, timeout}, cycles, run_count,
               exp_flags, exp_c, mdl_runs[7:0]);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b1; abort = 1'b0; ack = 1'b1;
    tick(); tick();
    Reset = 1'b0; start = 1'b0; ack = 1'b0;
    mdl_runs = 0; mdl_cycles = '0;
    total++;
    if ({init, req, busy, done, timeout} !== 5'b0 || cycles !== '0 || run_count !== 8'd0) begin
      bad++;
      $display("FAIL reset flags=%b cycles=%0d run_count=%0d want 0 0 0",
               {init, req, busy, done, timeout}, cycles, run_count);
    end
    tick();
    total++;
    if (busy !== 1'b0 || init !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b init=%b want 0 0", busy, init);
    end
  endtask

  task automatic test_basic();
    do_run(6, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_ack_held();
    do_run(0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    do_run(-1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    repeat (INIT_CYC + REQ_CYC + 5) tick();
    total++;
    if (cycles !== CW'(5) || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre cycles=%0d busy=%b want 5 1", cycles, busy);
    end
    abort = 1'b1; ack = 1'b1;
    tick();
    abort = 1'b0; ack = 1'b0;
    mdl_cycles = CW'(5);
    total++;
    if ({init, req, busy, done, timeout} !== 5'b0 || cycles !== mdl_cycles ||
        run_count !== mdl_runs[7:0]) begin
      bad++;
      $display("FAIL abort flags=%b cycles=%0d run_count=%0d want 00000 5 %0d",
               {init, req, busy, done, timeout}, cycles, run_count, mdl_runs[7:0]);
    end
    tick();
    total++;
    if (busy !== 1'b0 || cycles !== mdl_cycles) begin
      bad++;
      $display("FAIL abort_idle busy=%b cycles=%0d want 0 5", busy, cycles);
    end
    do_run(3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_ignored();
    apply_reset();
    do_run(3, 1'b0, 1'b1, 1'b1);
    do_run(2, 1'b0, 1'b1, 1'b1);
    total++;
    if (run_count !== 8'd2) begin
      bad++;
      $display("FAIL second_run_count got=%0d want=2", run_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      do_run(int'($urandom_range(0, TIMEOUT + 5)), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int n = 0; n < 256; n++) do_run(0, 1'b0, 1'b0, 1'b0);
    total++;
    if (run_count !== 8'd0) begin
      bad++;
      $display("FAIL wrap run_count=%0d want 0", run_count);
    end
    do_run(1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_req();
    start = 1'b1; tick(); start = 1'b0;
    repeat (INIT_CYC) tick();
    total++;
    if (req !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_req req=%b want 1", req);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mdl_runs = 0; mdl_cycles = '0;
    total++;
    if ({init, req, busy, done, timeout} !== 5'b0 || cycles !== '0 || run_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_in_req flags=%b cycles=%0d run_count=%0d want 0 0 0",
               {init, req, busy, done, timeout}, cycles, run_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_held();
    test_timeout();
    test_abort();
    test_start_ignored();
    test_random();
    test_back_to_back();
    test_reset_in_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
